// File: rtl/i2c_apb_arbiter.sv
// Two-requester round-robin APB sequencer in front of the I2C master's register port.
// Supports locked multi-transfer sequences and aborts stalled ACCESS phases after TIMEOUT cycles.
module i2c_apb_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input  logic       pclk_i,
  input  logic       preset_i,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic [1:0] write_i,
  input  logic [7:0] addr0_i,
  input  logic [7:0] addr1_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  output logic [1:0] gnt_o,
  output logic [1:0] done_o,
  output logic [7:0] rdata_o,
  output logic       err_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic [7:0] paddr_o,
  output logic [7:0] pwdata_o,
  output logic       pwrite_o,
  input  logic [7:0] prdata_i,
  input  logic       pready_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t          state;
  logic            last_owner;
  logic            owner;
  logic            locked;
  logic [TO_W-1:0] cnt;

  logic win_vld;
  logic win;

  // While locked only the lock holder may win; otherwise round-robin against last_owner.
  always_comb begin
    win_vld = 1'b0;
    win     = 1'b0;
    if (locked) begin
      win     = last_owner;
      win_vld = req_i[last_owner];
    end else if (req_i == 2'b11) begin
      win     = ~last_owner;
      win_vld = 1'b1;
    end else if (req_i[0]) begin
      win     = 1'b0;
      win_vld = 1'b1;
    end else if (req_i[1]) begin
      win     = 1'b1;
      win_vld = 1'b1;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state      <= IDLE;
      gnt_o      <= 2'b00;
      done_o     <= 2'b00;
      rdata_o    <= 8'h00;
      err_o      <= 1'b0;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      paddr_o    <= 8'h00;
      pwdata_o   <= 8'h00;
      pwrite_o   <= 1'b0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      locked     <= 1'b0;
      cnt        <= '0;
    end else begin
      done_o <= 2'b00;
      case (state)
        IDLE: begin
          // An abandoned lock is released so the other requester cannot starve.
          if (locked && !lock_i[last_owner] && !req_i[last_owner])
            locked <= 1'b0;
          if (win_vld) begin
            owner    <= win;
            gnt_o    <= win ? 2'b10 : 2'b01;
            paddr_o  <= win ? addr1_i : addr0_i;
            pwdata_o <= win ? wdata1_i : wdata0_i;
            pwrite_o <= write_i[win];
            psel_o   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            if (!pwrite_o)
              rdata_o <= prdata_i;
            err_o     <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            done_o    <= gnt_o;
            state     <= DONE;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            rdata_o   <= 8'h00;
            err_o     <= 1'b1;
            locked    <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            done_o    <= gnt_o;
            state     <= DONE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        DONE: begin
          last_owner <= owner;
          // A timed-out transfer must not re-arm the lock.
          if (!err_o)
            locked <= lock_i[owner];
          gnt_o <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
